// File: rtl/wishbone_gpio_slave_if.sv
// Wishbone classic-cycle bus bundle between a CPU master and the GPIO slave.
interface wishbone_gpio_slave_if;
   logic [31:0] wishbone_addr_i;
   logic [31:0] wishbone_data_i;
   logic [3:0]  wishbone_sel_i;
   logic        wishbone_we_i;
   logic        wishbone_stb_i;
   logic        wishbone_cyc_i;
   logic [31:0] wishbone_data_o;
   logic        wishbone_ack_o;

   modport slave (
      input  wishbone_addr_i, wishbone_data_i, wishbone_sel_i,
             wishbone_we_i, wishbone_stb_i, wishbone_cyc_i,
      output wishbone_data_o, wishbone_ack_o
   );

   modport master (
      output wishbone_addr_i, wishbone_data_i, wishbone_sel_i,
             wishbone_we_i, wishbone_stb_i, wishbone_cyc_i,
      input  wishbone_data_o, wishbone_ack_o
   );
endinterface

// File: rtl/wishbone_gpio_slave.sv
// Wishbone GPIO slave: OUT/DIR/IN/IRQ_STAT/IRQ_EN registers, one wait state per access,
// synchronized inputs with rising-edge interrupt capture on input-direction pins.
module wishbone_gpio_slave #(
   parameter int GPIO_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   wishbone_gpio_slave_if.slave  bus,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe_o,
   output logic                  irq_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   localparam logic [2:0] A_OUT  = 3'd0;
   localparam logic [2:0] A_DIR  = 3'd1;
   localparam logic [2:0] A_IN   = 3'd2;
   localparam logic [2:0] A_STAT = 3'd3;
   localparam logic [2:0] A_EN   = 3'd4;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   logic [0:0]            state;
   logic [GPIO_WIDTH-1:0] out_q, dir_q, stat_q, en_q;
   logic [GPIO_WIDTH-1:0] sync_p0, sync_p1, sync_p2;
   logic [GPIO_WIDTH-1:0] wmask, wdat, rise, clr;
   logic [31:0]           lane_m, rdata;
   logic [2:0]            reg_sel;
   logic                  access, wr;
   logic                  unused_addr;

   assign unused_addr = ^{bus.wishbone_addr_i[31:5], bus.wishbone_addr_i[1:0]};

   // Requests are only taken in IDLE, so a strobe held through the ack cycle is not re-accepted.
   assign access  = (state == ST_IDLE) & bus.wishbone_cyc_i & bus.wishbone_stb_i;
   assign wr      = access & bus.wishbone_we_i;
   assign reg_sel = bus.wishbone_addr_i[4:2];
   assign lane_m  = lane_mask(bus.wishbone_sel_i);
   assign wmask   = lane_m[GPIO_WIDTH-1:0];
   assign wdat    = bus.wishbone_data_i[GPIO_WIDTH-1:0];

   assign rise = sync_p1 & ~sync_p2 & ~dir_q;
   assign clr  = (wr && reg_sel == A_STAT) ? (wdat & wmask) : '0;

   assign gpio_o    = out_q;
   assign gpio_oe_o = dir_q;

   always_comb begin
      rdata = '0;
      case (reg_sel)
         A_OUT:   rdata[GPIO_WIDTH-1:0] = out_q;
         A_DIR:   rdata[GPIO_WIDTH-1:0] = dir_q;
         A_IN:    rdata[GPIO_WIDTH-1:0] = sync_p1;
         A_STAT:  rdata[GPIO_WIDTH-1:0] = stat_q;
         A_EN:    rdata[GPIO_WIDTH-1:0] = en_q;
         default: rdata = '0;
      endcase
   end

   // Bus handshake stage: ack and read data are registered on the accepting edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= ST_IDLE;
         bus.wishbone_ack_o  <= 1'b0;
         bus.wishbone_data_o <= '0;
      end else if (state == ST_IDLE) begin
         if (access) begin
            state               <= ST_ACK;
            bus.wishbone_ack_o  <= 1'b1;
            bus.wishbone_data_o <= bus.wishbone_we_i ? 32'd0 : rdata;
         end
      end else begin
         state               <= ST_IDLE;
         bus.wishbone_ack_o  <= 1'b0;
         bus.wishbone_data_o <= '0;
      end
   end

   // Register file and input synchronizer; an edge set outranks a same-cycle W1C.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         dir_q   <= '0;
         stat_q  <= '0;
         en_q    <= '0;
         sync_p0 <= '0;
         sync_p1 <= '0;
         sync_p2 <= '0;
         irq_o   <= 1'b0;
      end else begin
         sync_p0 <= gpio_i;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         if (wr && reg_sel == A_OUT) out_q <= (out_q & ~wmask) | (wdat & wmask);
         if (wr && reg_sel == A_DIR) dir_q <= (dir_q & ~wmask) | (wdat & wmask);
         if (wr && reg_sel == A_EN)  en_q  <= (en_q  & ~wmask) | (wdat & wmask);
         stat_q <= (stat_q & ~clr) | rise;
         irq_o  <= |(stat_q & en_q);
      end
   end

endmodule

// File: doc/wishbone_gpio_slave.md
Name: wishbone_gpio_slave

Overview:
Wishbone classic-cycle slave (responder) exposing a GPIO port to the CPU's Wishbone bus interface. Decodes five 32-bit registers: output data, direction, synchronized input, interrupt status and interrupt enable. Drives pad-side output/output-enable and a level interrupt toward the interrupt controller. Every accepted access gets exactly one registered ack pulse, with one wait state.

Parameters:
GPIO_WIDTH, 32, number of GPIO pins (1..32); register bits at or above GPIO_WIDTH read 0 and ignore writes.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
wishbone_addr_i  input  32  byte address; only [4:2] decoded
wishbone_data_i  input  32  write data
wishbone_sel_i  input  4  byte lane enables
wishbone_we_i  input  1  1 = write, 0 = read
wishbone_stb_i  input  1  strobe
wishbone_cyc_i  input  1  bus cycle valid
wishbone_data_o  output  32  read data, valid while ack_o = 1
wishbone_ack_o  output  1  transfer acknowledge
gpio_i  input  GPIO_WIDTH  asynchronous pad inputs
gpio_o  output  GPIO_WIDTH  pad output values (= OUT register)
gpio_oe_o  output  GPIO_WIDTH  pad output enables (= DIR register, 1 = drive)
irq_o  output  1  level interrupt, registered

Behaviour:
- Reset (rst = 0, takes effect asynchronously): OUT, DIR, IRQ_STAT and IRQ_EN are 0; both sync flops and the edge-history flop are 0; wishbone_ack_o = 0, wishbone_data_o = 0, irq_o = 0, gpio_o = 0, gpio_oe_o = 0.
- Register map (addr[4:2]):
  - 0 OUT: RW.
  - 1 DIR: RW.
  - 2 IN: RO, synchronized pins.
  - 3 IRQ_STAT: read; write-1-to-clear.
  - 4 IRQ_EN: RW.
  - 5..7: read 0; writes ignored but still acked.
- States: IDLE, ACK.
  - IDLE: cyc_i & stb_i sampled high on an edge -> access is performed on that edge and the block goes to ACK. wishbone_ack_o = 1 during the following cycle. For reads, wishbone_data_o is registered on the same edge.
  - ACK: unconditional return to IDLE on the next edge. ack_o = 0 and data_o = 0 after that edge. A request is never accepted while in ACK, so a stb held high through the ack cycle does not cause a double access.
  - Back-to-back: stb still high in the cycle after ack -> new access accepted. Maximum rate is one transfer per 2 cycles.
- Latency: request seen at edge N -> ack high for cycle N..N+1 -> master samples ack at edge N+1.
- Byte lanes: writes update only the bytes with sel_i set, for OUT, DIR and IRQ_EN. For IRQ_STAT, a bit is cleared only if its data bit = 1 and its lane is selected. Reads return all 32 bits regardless of sel_i.
- Abort: if cyc_i/stb_i drop during the ack cycle, the write has already committed and the ack pulse still occurs; the master ignores it. No other bus-error signalling.
- Input path:
  - Two-flop synchronizer on gpio_i feeds IN. IN reflects a pin change 2 edges after it settles.
  - A third history flop detects rising edges: sync = 1 and prev = 0, for pins with DIR = 0 only.
  - A detected edge sets the IRQ_STAT bit on the next edge.
- Simultaneous edge set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- irq_o is registered: irq_o <= |(IRQ_STAT & IRQ_EN). It rises one edge after the stat bit sets and falls one edge after the clear or disable.
- Widths: internal registers are GPIO_WIDTH wide, zero-extended to 32 on reads. Writes to bits at or above GPIO_WIDTH are dropped.

Test Plan:
- Reset/readback: assert rst low mid-transaction, release, read all 8 addresses -> every register reads 0x00000000; ack_o is 0 during reset; each read ack arrives exactly 1 cycle after stb.
- Write/read with byte lanes: write OUT = 0xA5A5A5A5 with sel = 4'b1111, then 0x00FF0000 with sel = 4'b0100 -> OUT reads 0xA5FFA5A5 and gpio_o matches; DIR = 0x0000FFFF -> gpio_oe_o = 0x0000FFFF.
- Held strobe: master holds stb/cyc high for 4 cycles on one write -> exactly 2 acks (cycles 2 and 4); ack never high in consecutive cycles.
- Synchronizer/IN: drive gpio_i = 0x12345678 -> IN reads the old value if sampled within 2 edges, and 0x12345678 from the 3rd edge on.
- Interrupt:
  - IRQ_EN = 0x1, DIR = 0, rising edge on pin 0 -> IRQ_STAT = 0x1; irq_o rises.
  - Write IRQ_STAT = 0x1 -> irq_o falls.
  - Rising edge on an output-direction pin -> no stat bit set.
- Set/clear collision: schedule a pin-3 rising edge on the same edge as a W1C of bit 3 -> IRQ_STAT bit 3 remains 1; irq_o stays high if enabled.
